reg_group_decoder: RTL
======================

# reg_group_decoder

Downstream stage of the control-system request arbiter. Takes the single arbitrated request bus (req_*) and turns each transfer into an APB-style setup/access cycle on one of GRP_NUM register-group ports, selected by the upper address bits. It returns one req_ready pulse with read data per transfer. Unmapped group indices complete locally with a fixed error pattern and are counted.

## Interface
- ADDR_WIDTH, 21, request address width
- DATA_WIDTH, 16, data width
- GRP_SEL_W, 3, upper address bits used as group index
- GRP_NUM, 5, number of implemented groups (1..2^GRP_SEL_W); indices >= GRP_NUM are unmapped
- OFF_WIDTH, ADDR_WIDTH-GRP_SEL_W, offset width forwarded to groups
- ERR_DATA, 16'hDEAD, read data returned for unmapped accesses

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_addr  in  ADDR_WIDTH  request address; group = req_addr[ADDR_WIDTH-1 -: GRP_SEL_W]
- req_write  in  1  1 = write
- req_sel  in  1  request valid, held high until req_ready is seen
- req_wdata  in  DATA_WIDTH  write data
- req_ready  out  1  single-cycle completion pulse
- req_rdata  out  DATA_WIDTH  read data, valid while req_ready=1
- grp_sel  out  GRP_NUM  one-hot group select
- grp_enable  out  1  access phase
- grp_write  out  1  write flag to groups
- grp_addr  out  OFF_WIDTH  offset within group
- grp_wdata  out  DATA_WIDTH  write data to groups
- grp_ready  in  GRP_NUM  per-group ready
- grp_rdata  in  GRP_NUM*DATA_WIDTH  flattened read data; group g at [g*DATA_WIDTH +: DATA_WIDTH]
- err_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  16  saturating count of unmapped accesses

## Operation
- FSM states are one-hot: IDLE, SETUP, ACCESS, DONE.
- **armed flag.** Reset value 1. Cleared on entering DONE. Set in any cycle where req_sel=0 is sampled. This prevents relaunching on the trailing req_sel cycle.
- **IDLE.** When req_sel=1 and armed=1, register addr, write, wdata and group index.
  - Mapped index: go to SETUP.
  - Unmapped index: go to DONE with rdata=ERR_DATA and increment err_cnt. No grp_* activity.
- **SETUP.** grp_sel[idx]=1, grp_enable=0, go to ACCESS.
- **ACCESS.** grp_sel[idx]=1, grp_enable=1. Wait with no timeout; the upstream arbiter owns the timeout.
  - On grp_ready[idx]=1: capture req_rdata (group data if read, 0 if write) and go to DONE.
- **DONE.** req_ready=1 for exactly one cycle, then go to IDLE.
- **Abort.** If req_sel=0 is sampled in SETUP or ACCESS, drop grp_sel/grp_enable and go to IDLE. No req_ready is issued and err_cnt is unchanged.
- **Ready gating.** grp_ready of non-selected groups is ignored.
- **err_cnt.** Saturates at 16'hFFFF. If err_clr and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- Reset values:
  - req_ready=0, req_rdata=0.
  - grp_sel=0, grp_enable=0, grp_write=0, grp_addr=0, grp_wdata=0.
  - err_cnt=0, state=IDLE, armed=1.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- **Mapped transfer.** req_sel seen in cycle N (IDLE), SETUP in N+1, ACCESS in N+2. If grp_ready=1 at N+2, req_ready=1 at N+3. Minimum latency is 3 cycles; each ACCESS wait cycle adds 1.
- **Unmapped transfer.** req_ready at N+1.
- **Stability.** grp_addr, grp_wdata and grp_write are stable from SETUP through the end of ACCESS.
- **Back-to-back.** The next launch needs at least one req_sel=0 sample after DONE.
- **Reset mid-transfer.** Everything returns to reset values immediately; no req_ready is issued.

## Structure
- Shared package ctrl_sys_pkg holds:
  - the state one-hot localparams;
  - ERR_DATA default;
  - the GRP_SEL_W default.
- One sub-module, sat_cnt16: a 16-bit saturating counter with clear and inc, where clear has priority.
- The rest is a single always_ff FSM plus a group-mux for rdata/ready.

## Test plan
- **Read group 2.** addr=21'h08_0010 (idx 2, offset 0x10), grp_ready[2] high at first ACCESS, grp_rdata[2]=16'h1234. Expect grp_sel=5'b00100, grp_addr=18'h10, req_ready at N+3, req_rdata=16'h1234.
- **Write group 0 with 3 wait cycles.** wdata=16'hA5A5, grp_ready[0] after 3 ACCESS cycles. Expect grp_write=1, grp_wdata=16'hA5A5 stable throughout, req_ready at N+6, req_rdata=0.
- **Unmapped index 6.** Expect req_ready at N+1, req_rdata=16'hDEAD, no grp_sel activity, err_cnt 0→1. With err_clr asserted in the same cycle as the increment, expect err_cnt=0.
- **Ignored ready and abort.** grp_ready[1] asserted while group 3 is accessed: no completion. Then req_sel dropped in ACCESS: grp_sel=0 next cycle, no req_ready, FSM back in IDLE.
- **Held req_sel and mid-ACCESS reset.**
  - req_sel held high for 2 cycles after DONE: exactly one transfer is issued.
  - rst asserted in ACCESS: all outputs go to 0 asynchronously.
  - After reset, a new read completes normally.

Source files
------------

// File: rtl/ctrl_sys_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_sys_pkg
// Definitions shared by the control-system request path:
//   - one-hot state codes for the register-group decoder FSM
//   - default group-index width and the unmapped-access read pattern
// ---------------------------------------------------------------------------
package ctrl_sys_pkg;

    localparam logic [3:0] ST_IDLE   = 4'b0001;
    localparam logic [3:0] ST_SETUP  = 4'b0010;
    localparam logic [3:0] ST_ACCESS = 4'b0100;
    localparam logic [3:0] ST_DONE   = 4'b1000;

    localparam int          GRP_SEL_W_DEF = 3;
    localparam logic [15:0] ERR_DATA_DEF  = 16'hDEAD;

    typedef enum logic [3:0] {
        S_IDLE   = ST_IDLE,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE
    } state_t;

endpackage

// File: rtl/sat_cnt16.sv
// ---------------------------------------------------------------------------
// sat_cnt16
// 16-bit counter that sticks at 16'hFFFF. Clear has priority over increment.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_clr      synchronous clear
//   i_inc      increment request
//   o_cnt      current count
// ---------------------------------------------------------------------------
module sat_cnt16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [15:0] o_cnt
);

    logic [15:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_group_decoder.sv
// ---------------------------------------------------------------------------
// reg_group_decoder
// Converts one arbitrated request into an APB-style setup/access cycle on the
// register group chosen by the upper address bits. Unmapped group indices
// complete locally with ERR_DATA and bump a saturating error counter.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   req_addr/write/sel/wdata       upstream request (req_sel held to ready)
//   req_ready, req_rdata           one-cycle completion pulse + read data
//   grp_sel/enable/write/addr/wdata  group-side bus (one-hot select)
//   grp_ready, grp_rdata           per-group ready and flattened read data
//   err_clr, err_cnt               clear / count of unmapped accesses
// ---------------------------------------------------------------------------
module reg_group_decoder
    import ctrl_sys_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 21,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    GRP_SEL_W  = GRP_SEL_W_DEF,
    parameter int                    GRP_NUM    = 5,
    parameter int                    OFF_WIDTH  = ADDR_WIDTH - GRP_SEL_W,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = ERR_DATA_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic                          req_write,
    input  logic                          req_sel,
    input  logic [DATA_WIDTH-1:0]         req_wdata,
    output logic                          req_ready,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [GRP_NUM-1:0]            grp_sel,
    output logic                          grp_enable,
    output logic                          grp_write,
    output logic [OFF_WIDTH-1:0]          grp_addr,
    output logic [DATA_WIDTH-1:0]         grp_wdata,
    input  logic [GRP_NUM-1:0]            grp_ready,
    input  logic [GRP_NUM*DATA_WIDTH-1:0] grp_rdata,
    input  logic                          err_clr,
    output logic [15:0]                   err_cnt
);

    state_t                  r_state;
    logic                    r_armed;
    logic [DATA_WIDTH-1:0]   r_req_rdata;
    logic [GRP_NUM-1:0]      r_grp_sel;
    logic                    r_grp_enable;
    logic                    r_grp_write;
    logic [OFF_WIDTH-1:0]    r_grp_addr;
    logic [DATA_WIDTH-1:0]   r_grp_wdata;

    logic [GRP_SEL_W-1:0]    w_req_idx;
    logic [OFF_WIDTH-1:0]    w_req_off;
    logic                    w_mapped;
    logic                    w_launch;
    logic                    w_err_inc;
    logic [GRP_NUM-1:0]      w_req_onehot;
    logic                    w_grp_ready;
    logic [DATA_WIDTH-1:0]   w_grp_rdata;

    assign w_req_idx = req_addr[ADDR_WIDTH-1 -: GRP_SEL_W];
    assign w_req_off = req_addr[OFF_WIDTH-1:0];
    // One extra bit so GRP_NUM == 2**GRP_SEL_W compares correctly.
    assign w_mapped  = ({1'b0, w_req_idx} < (GRP_SEL_W+1)'(GRP_NUM));
    assign w_launch  = (r_state == S_IDLE) && req_sel && r_armed;
    assign w_err_inc = w_launch && !w_mapped;

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is inferred.
    always_comb begin
        w_req_onehot = '0;
        for (int g = 0; g < GRP_NUM; g++) begin
            w_req_onehot[g] = (w_req_idx == GRP_SEL_W'(g));
        end
    end

    // The registered one-hot select doubles as the group index: ready and
    // read data of non-selected groups are masked out here.
    always_comb begin
        w_grp_ready = |(grp_ready & r_grp_sel);
        w_grp_rdata = '0;
        for (int g = 0; g < GRP_NUM; g++) begin
            if (r_grp_sel[g]) begin
                w_grp_rdata = w_grp_rdata | grp_rdata[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_armed      <= 1'b1;
            r_req_rdata  <= '0;
            r_grp_sel    <= '0;
            r_grp_enable <= 1'b0;
            r_grp_write  <= 1'b0;
            r_grp_addr   <= '0;
            r_grp_wdata  <= '0;
        end else begin
            // Any low sample of req_sel re-arms; this keeps the trailing
            // req_sel cycle after DONE from starting a second transfer.
            if (!req_sel) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        if (w_mapped) begin
                            r_grp_sel   <= w_req_onehot;
                            r_grp_write <= req_write;
                            r_grp_addr  <= w_req_off;
                            r_grp_wdata <= req_wdata;
                            r_state     <= S_SETUP;
                        end else begin
                            // Local completion; the group bus stays quiet.
                            r_req_rdata <= ERR_DATA;
                            r_armed     <= 1'b0;
                            r_state     <= S_DONE;
                        end
                    end
                end

                S_SETUP: begin
                    if (!req_sel) begin
                        r_grp_sel <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_grp_enable <= 1'b1;
                        r_state      <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (!req_sel) begin
                        r_grp_sel    <= '0;
                        r_grp_enable <= 1'b0;
                        r_state      <= S_IDLE;
                    end else if (w_grp_ready) begin
                        r_req_rdata  <= r_grp_write ? '0 : w_grp_rdata;
                        r_grp_sel    <= '0;
                        r_grp_enable <= 1'b0;
                        r_armed      <= 1'b0;
                        r_state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_grp_sel    <= '0;
                    r_grp_enable <= 1'b0;
                end
            endcase
        end
    end

    sat_cnt16 u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (err_clr),
        .i_inc (w_err_inc),
        .o_cnt (err_cnt)
    );

    assign req_ready  = (r_state == S_DONE);
    assign req_rdata  = r_req_rdata;
    assign grp_sel    = r_grp_sel;
    assign grp_enable = r_grp_enable;
    assign grp_write  = r_grp_write;
    assign grp_addr   = r_grp_addr;
    assign grp_wdata  = r_grp_wdata;

endmodule
